sprite_palette_bank: RTL
========================

# sprite_palette_bank

Parametrised, writable multi-palette colour lookup for sprite and tile rendering. It holds NUM_PAL palettes of 2^INDEX_W entries each, converts a per-pixel (palette, index) pair to RGB through a two-stage pipeline, and applies a global frame-timed fade. Index 0 can optionally be treated as transparent. It sits between the sprite ROM address/index logic and the VGA colour mux, and replaces the per-sprite fixed palette ROMs.

## Interface
- INDEX_W, 4, colour index width; each palette has 2^INDEX_W entries
- COLOR_W, 4, width of each of red/green/blue
- NUM_PAL, 4, number of palettes; must be a power of two, at least 1
- FADE_DIV, 2, frame_tick pulses per fade step (at least 1)
- TRANSP_EN, 1, when 1, index 0 is transparent
- Clk  in  1  system clock; every register uses the rising edge
- Reset  in  1  synchronous, active-high reset
- in_valid  in  1  lookup request this cycle
- pal_sel  in  log2(NUM_PAL) (min 1)  palette for the lookup
- index  in  INDEX_W  colour index for the lookup
- wr_en  in  1  palette write strobe
- wr_pal  in  log2(NUM_PAL) (min 1)  palette to write
- wr_addr  in  INDEX_W  entry to write
- wr_data  in  3*COLOR_W  {red, green, blue} to write
- frame_tick  in  1  one-cycle pulse per frame (vsync edge)
- fade_cmd  in  2  00 none, 01 fade out, 10 fade in, 11 snap to full brightness
- out_valid  out  1  red/green/blue/transparent valid
- red, green, blue  out  COLOR_W each  looked-up colour after fade
- transparent  out  1  pixel is transparent
- busy  out  1  init sweep in progress
- fade_done  out  1  one-cycle pulse when a fade reaches its end point

## Operation
- Storage: NUM_PAL*2^INDEX_W words of 3*COLOR_W bits, addressed {pal, index}. Synchronous read.
- INIT state (entered on Reset): an address counter sweeps 0..NUM_PAL*2^INDEX_W-1 and writes 0 to one word per cycle. busy=1 for the whole sweep. The FSM then enters RUN and busy drops to 0.
  - During INIT, wr_en and fade_cmd are ignored.
  - During INIT, in_valid is accepted, but out_valid is forced to 0.
- RUN: a write with wr_en=1 commits at the clock edge. A read of the same address in the same cycle returns the old data. A read one cycle later returns the new data.
- Lookup pipeline:
  - Stage 1 registers the RAM word, the valid bit, and the flag (index==0 && TRANSP_EN).
  - Stage 2 computes each channel as max(c - fade_level, 0) in COLOR_W bits with saturation, then registers the outputs.
  - If the transparency flag is set, red, green and blue are 0 and transparent=1.
- Fade FSM, states FIDLE and FADING. fade_level ranges 0..2^COLOR_W-1. At 0 the image is at full brightness; at max it is black.
  - Commands are accepted in RUN, in either FIDLE or FADING.
  - 01: target = max, enter FADING. 10: target = 0, enter FADING. In both cases the tick divider clears to 0.
  - 11: fade_level=0 and FIDLE on the next edge, with no fade_done pulse.
  - A new command during FADING overrides the current fade. The level continues from its current value.
  - In FADING, each frame_tick increments the divider. When the divider reaches FADE_DIV-1 it wraps to 0, and fade_level steps by 1 toward the target.
  - On the edge where fade_level becomes equal to the target: fade_done=1 for one cycle, and the FSM enters FIDLE.
  - A command whose target equals the current level: fade_done pulses on the next edge, and the FSM stays in FIDLE.
  - If fade_cmd and frame_tick arrive in the same cycle, the command wins and that tick is discarded.
- Reset values: fade_level=0, FIDLE, divider=0, all pipeline valids=0, and every output 0 (busy=1 from the first cycle after Reset).

## Timing
- Lookup latency is 2 cycles: a request at edge N produces out_valid at N+2. Throughput is one lookup per cycle. There is no backpressure.
- Init lasts exactly NUM_PAL*2^INDEX_W cycles after Reset deasserts. busy is 1 for exactly that many cycles.
- A fade_level change takes effect on the stage-2 result computed in the same cycle as the change. Pixels already registered in stage 2 are not altered.
- Reset asserted mid-operation:
  - Pipeline valids clear on that edge.
  - Any in-flight write is dropped unless it commits on that same edge.
  - The init sweep restarts from address 0.

## Test plan
- Reset, then count busy cycles with defaults: exactly 64 cycles. Any lookup issued during busy returns out_valid=0.
- Write pal 2, idx 5 = 0xF84. Look it up the next cycle: out_valid 2 cycles later with red=F, green=8, blue=4, transparent=0. Look up pal 1, idx 5: 000.
- Write 0xABC and read the same address in the same cycle: the result is the old value 000. The following read returns ABC.
- Look up idx 0 on every palette with TRANSP_EN=1: transparent=1, rgb=000. With TRANSP_EN=0: transparent=0, and rgb is the stored value.
- Entry 0xF84, FADE_DIV=2, fade_cmd=01, then 30 frame_ticks:
  - fade_level reaches F after 30 ticks, with fade_done pulsing once.
  - After 10 ticks (level 5) the output is A,3,0.
  - Then fade_cmd=10 mid-fade: the level returns toward 0.
  - fade_cmd=11: full brightness next cycle, with no fade_done.
- Back-to-back lookups across 256 consecutive cycles: one out_valid per cycle, in order, with no gaps. Assert Reset mid-stream: out_valid=0 on the next cycle, and busy reasserts for 64 cycles.

Source files
------------

// File: rtl/sprite_palette_bank.sv
// rtl/sprite_palette_bank.sv - multi-palette colour lookup with global frame-timed fade
// Zeroing sweep after reset, two-stage lookup pipeline, optional index-0 transparency.
module sprite_palette_bank #(
  parameter int INDEX_W   = 4,
  parameter int COLOR_W   = 4,
  parameter int NUM_PAL   = 4,
  parameter int FADE_DIV  = 2,
  parameter int TRANSP_EN = 1,
  localparam int PAL_W    = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   in_valid,
  input  logic [PAL_W-1:0]       pal_sel,
  input  logic [INDEX_W-1:0]     index,
  input  logic                   wr_en,
  input  logic [PAL_W-1:0]       wr_pal,
  input  logic [INDEX_W-1:0]     wr_addr,
  input  logic [3*COLOR_W-1:0]   wr_data,
  input  logic                   frame_tick,
  input  logic [1:0]             fade_cmd,
  output logic                   out_valid,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   transparent,
  output logic                   busy,
  output logic                   fade_done
);

  localparam int DEPTH  = NUM_PAL * (2 ** INDEX_W);
  localparam int ADDR_W = PAL_W + INDEX_W;
  localparam int RGB_W  = 3 * COLOR_W;
  localparam int DIV_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [COLOR_W-1:0] LEVEL_MAX = '1;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(FADE_DIV - 1);

  typedef enum logic {INIT, RUN} mode_t;
  typedef enum logic {FIDLE, FADING} fade_t;

  mode_t              mode;
  fade_t              fstate;
  logic [ADDR_W-1:0]  init_addr;
  logic [RGB_W-1:0]   mem [DEPTH];
  logic [RGB_W-1:0]   ram_q;
  logic               v1;
  logic               t1;
  logic [COLOR_W-1:0] fade_level;
  logic [COLOR_W-1:0] target;
  logic [DIV_W-1:0]   div;

  logic [PAL_W-1:0]   rd_pal;
  logic [PAL_W-1:0]   wr_pal_eff;
  logic [ADDR_W-1:0]  rd_full;
  logic [ADDR_W-1:0]  wr_full;
  logic [COLOR_W-1:0] cmd_target;
  logic [COLOR_W-1:0] level_step;

  // With a single palette the palette bits carry no information and must not address past DEPTH.
  assign rd_pal     = (NUM_PAL > 1) ? pal_sel : '0;
  assign wr_pal_eff = (NUM_PAL > 1) ? wr_pal : '0;
  assign rd_full    = {rd_pal, index};
  assign wr_full    = {wr_pal_eff, wr_addr};
  assign cmd_target = fade_cmd[0] ? LEVEL_MAX : '0;
  assign level_step = (target > fade_level) ? fade_level + 1'b1 : fade_level - 1'b1;

  function automatic logic [COLOR_W-1:0] fade_ch(input logic [COLOR_W-1:0] c,
                                                 input logic [COLOR_W-1:0] l);
    return (c > l) ? c - l : '0;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode      <= INIT;
      init_addr <= '0;
      busy      <= 1'b1;
    end else if (mode == INIT) begin
      if (init_addr == LAST_ADDR) begin
        mode <= RUN;
        busy <= 1'b0;
      end
      init_addr <= init_addr + 1'b1;
    end
  end

  // Read and write share one block so a same-address read returns the pre-write word.
  always_ff @(posedge Clk) begin
    if (mode == INIT)
      mem[init_addr] <= '0;
    else if (wr_en)
      mem[wr_full] <= wr_data;
    ram_q <= mem[rd_full];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1 <= 1'b0;
      t1 <= 1'b0;
    end else begin
      v1 <= in_valid && (mode == RUN);
      t1 <= (TRANSP_EN != 0) && (index == '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid   <= 1'b0;
      transparent <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      out_valid   <= v1;
      transparent <= v1 && t1;
      if (t1) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else begin
        red   <= fade_ch(ram_q[RGB_W-1 -: COLOR_W], fade_level);
        green <= fade_ch(ram_q[2*COLOR_W-1 -: COLOR_W], fade_level);
        blue  <= fade_ch(ram_q[COLOR_W-1:0], fade_level);
      end
    end
  end

  // A command in the same cycle as frame_tick takes priority and the tick is lost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fstate     <= FIDLE;
      fade_level <= '0;
      target     <= '0;
      div        <= '0;
      fade_done  <= 1'b0;
    end else begin
      fade_done <= 1'b0;
      if (mode == RUN && fade_cmd != 2'b00) begin
        div <= '0;
        case (fade_cmd)
          2'b01, 2'b10: begin
            target <= cmd_target;
            if (fade_level == cmd_target) begin
              fade_done <= 1'b1;
              fstate    <= FIDLE;
            end else begin
              fstate <= FADING;
            end
          end
          default: begin
            fade_level <= '0;
            fstate     <= FIDLE;
          end
        endcase
      end else if (fstate == FADING && frame_tick) begin
        if (div == DIV_LAST) begin
          div        <= '0;
          fade_level <= level_step;
          if (level_step == target) begin
            fade_done <= 1'b1;
            fstate    <= FIDLE;
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

endmodule
